// File: rtl/clint_trap_ctrl_pkg.sv
// Shared CSR definitions for the trap sequencer: CSR addresses, cause codes,
// mstatus bit positions, FSM encoding and the mstatus/target update helpers.
package clint_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam logic [31:0] CAUSE_ECALL     = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [31:0] CAUSE_IRQ_EXT   = {1'b1, 31'd11};
  localparam logic [31:0] CAUSE_IRQ_TIMER = {1'b1, 31'd7};

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_T_EPC   = 3'd1,
    S_T_CAUSE = 3'd2,
    S_T_STAT  = 3'd3,
    S_R_STAT  = 3'd4,
    S_JUMP    = 3'd5
  } state_t;

  // mstatus on trap entry: stash MIE in MPIE, disable, enter M-mode
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus on mret: restore MIE from MPIE, re-arm MPIE
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap vector: direct base, or base + 4*code for interrupts in vectored mode
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic [31:0] cause,
                                              input bit          vec_en);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (vec_en && (mtvec[1:0] == 2'b01) && cause[31])
      return base + {cause[29:0], 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/clint_trap_ctrl_if.sv
// CSR-file side of the trap sequencer: the shared write port plus the live
// CSR values the sequencer reads back.
interface clint_trap_ctrl_if;
  logic        we_clint;
  logic [11:0] wa_clint;
  logic [31:0] wd_clint;
  logic        csr_we_ex;
  logic [31:0] clint_csr_mstatus;
  logic [31:0] clint_csr_mepc;
  logic [31:0] clint_csr_mtvec;
  logic        interrupt_enable;

  modport master (
    output we_clint, wa_clint, wd_clint,
    input  csr_we_ex, clint_csr_mstatus, clint_csr_mepc, clint_csr_mtvec, interrupt_enable
  );

  modport slave (
    input  we_clint, wa_clint, wd_clint,
    output csr_we_ex, clint_csr_mstatus, clint_csr_mepc, clint_csr_mtvec, interrupt_enable
  );
endinterface

// File: rtl/clint_trap_ctrl_irq_sync.sv
// Reset-to-0 multi-flop synchronizer for one asynchronous IRQ level.
module clint_trap_ctrl_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);
  logic [STAGES-1:0] r_sync;

  // shift the raw level through STAGES flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[STAGES-1];
endmodule

// File: rtl/clint_trap_ctrl.sv
// Trap/interrupt sequencer: accepts ecall/ebreak/mret and timer/external IRQs
// in IDLE, writes mepc/mcause/mstatus one per cycle through the shared CSR
// port (yielding to EX), then redirects fetch. Front end is stalled while busy.
module clint_trap_ctrl
  import clint_trap_ctrl_pkg::*;
#(
  parameter bit VECTORED_EN     = 1'b1,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_id_valid,
  input  logic [31:0]              i_id_pc,
  input  logic                     i_id_ecall,
  input  logic                     i_id_ebreak,
  input  logic                     i_id_mret,
  input  logic                     i_irq_timer,
  input  logic                     i_irq_ext,
  clint_trap_ctrl_if.master        csr,
  output logic                     o_clint_stall,
  output logic                     o_clint_flush,
  output logic                     o_pc_redirect,
  output logic [31:0]              o_redirect_pc
);

  // index 1 = external, index 0 = timer
  logic [1:0]  w_irq_raw;
  logic [1:0]  w_irq_s;

  state_t      r_state;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic [31:0] r_target;
  logic        r_is_mret;

  logic        w_accept;
  logic        w_is_mret;
  logic [31:0] w_cause;

  assign w_irq_raw = {i_irq_ext, i_irq_timer};

  for (genvar g = 0; g < 2; g++) begin : g_sync
    clint_trap_ctrl_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (w_irq_raw[g]),
      .o_sync  (w_irq_s[g])
    );
  end

  // IDLE-only event arbitration: mret > ecall > ebreak > ext > timer
  always_comb begin
    w_accept  = 1'b0;
    w_is_mret = 1'b0;
    w_cause   = '0;
    if (r_state == S_IDLE && i_id_valid) begin
      if (i_id_mret) begin
        w_accept  = 1'b1;
        w_is_mret = 1'b1;
      end else if (i_id_ecall) begin
        w_accept = 1'b1;
        w_cause  = CAUSE_ECALL;
      end else if (i_id_ebreak) begin
        w_accept = 1'b1;
        w_cause  = CAUSE_EBREAK;
      end else if (csr.interrupt_enable && w_irq_s[1]) begin
        w_accept = 1'b1;
        w_cause  = CAUSE_IRQ_EXT;
      end else if (csr.interrupt_enable && w_irq_s[0]) begin
        w_accept = 1'b1;
        w_cause  = CAUSE_IRQ_TIMER;
      end
    end
  end

  // sequencer FSM; CSR-write states advance only when EX leaves the port free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_epc     <= '0;
      r_cause   <= '0;
      r_target  <= '0;
      r_is_mret <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_epc     <= i_id_pc;
          r_cause   <= w_cause;
          r_target  <= trap_target(csr.clint_csr_mtvec, w_cause, VECTORED_EN);
          r_is_mret <= w_is_mret;
          r_state   <= w_is_mret ? S_R_STAT : S_T_EPC;
        end
        S_T_EPC:   if (!csr.csr_we_ex) r_state <= S_T_CAUSE;
        S_T_CAUSE: if (!csr.csr_we_ex) r_state <= S_T_STAT;
        S_T_STAT:  if (!csr.csr_we_ex) r_state <= S_JUMP;
        S_R_STAT:  if (!csr.csr_we_ex) r_state <= S_JUMP;
        S_JUMP:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // outputs decode from state; mstatus images use the live value so EX
  // updates made before our write are not lost
  always_comb begin
    csr.we_clint  = 1'b0;
    csr.wa_clint  = '0;
    csr.wd_clint  = '0;
    o_pc_redirect = 1'b0;
    o_redirect_pc = '0;
    case (r_state)
      S_T_EPC: begin
        csr.we_clint = 1'b1;
        csr.wa_clint = CSR_MEPC;
        csr.wd_clint = r_epc;
      end
      S_T_CAUSE: begin
        csr.we_clint = 1'b1;
        csr.wa_clint = CSR_MCAUSE;
        csr.wd_clint = r_cause;
      end
      S_T_STAT: begin
        csr.we_clint = 1'b1;
        csr.wa_clint = CSR_MSTATUS;
        csr.wd_clint = trap_mstatus(csr.clint_csr_mstatus);
      end
      S_R_STAT: begin
        csr.we_clint = 1'b1;
        csr.wa_clint = CSR_MSTATUS;
        csr.wd_clint = mret_mstatus(csr.clint_csr_mstatus);
      end
      S_JUMP: begin
        o_pc_redirect = 1'b1;
        o_redirect_pc = r_is_mret ? csr.clint_csr_mepc : r_target;
      end
      default: ;
    endcase
  end

  assign o_clint_stall = (r_state != S_IDLE);
  assign o_clint_flush = w_accept;

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Bench for clint_trap_ctrl: directed scenarios then randomized events, all
// checked against a transaction-level model of trap/mret effects. The bench
// also plays the CSR file, committing every accepted write it observes.
module tb_clint_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic        id_ecall = 1'b0, id_ebreak = 1'b0, id_mret = 1'b0;
  logic        irq_timer = 1'b0, irq_ext = 1'b0;
  logic        ex = 1'b0;
  logic        stall, flush, redir;
  logic [31:0] redir_pc;

  // CSR file contents as seen by the DUT
  logic [31:0] m_mstatus = '0, m_mepc = '0, m_mtvec = '0;

  int vectors = 0, miscompares = 0;
  bit          pend_v = 1'b0;
  logic [11:0] pend_a = '0;
  logic [31:0] pend_d = '0;
  int ex_mode = 0, busy_left = 0;

  clint_trap_ctrl_if ifc();

  assign ifc.csr_we_ex         = ex;
  assign ifc.clint_csr_mstatus = m_mstatus;
  assign ifc.clint_csr_mepc    = m_mepc;
  assign ifc.clint_csr_mtvec   = m_mtvec;
  assign ifc.interrupt_enable  = m_mstatus[3];

  clint_trap_ctrl #(.VECTORED_EN(1'b1), .IRQ_SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(id_valid), .i_id_pc(id_pc),
    .i_id_ecall(id_ecall), .i_id_ebreak(id_ebreak), .i_id_mret(id_mret),
    .i_irq_timer(irq_timer), .i_irq_ext(irq_ext),
    .csr(ifc),
    .o_clint_stall(stall), .o_clint_flush(flush),
    .o_pc_redirect(redir), .o_redirect_pc(redir_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // rising edge: commit last accepted write, then drive EX port usage
  task automatic tick();
    @(posedge clk); #1;
    if (pend_v) begin
      case (pend_a)
        12'h300: m_mstatus = pend_d;
        12'h341: m_mepc    = pend_d;
        default: ;
      endcase
      pend_v = 1'b0;
    end
    case (ex_mode)
      1: ex = ($urandom_range(0, 3) == 0);
      2: begin ex = (busy_left > 0); if (busy_left > 0) busy_left--; end
      default: ex = 1'b0;
    endcase
  endtask

  // falling edge: sample, remember a write the CSR file will take
  task automatic samp();
    @(negedge clk);
    if (ifc.we_clint && !ex) begin
      pend_v = 1'b1; pend_a = ifc.wa_clint; pend_d = ifc.wd_clint;
    end
  endtask

  task automatic clear_id();
    id_valid = 1'b0; id_ecall = 1'b0; id_ebreak = 1'b0; id_mret = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(); samp();
      chk("idle_stall", 32'(stall), 32'd0);
    end
  endtask

  // instr: 0 none (IRQ only), 1 ecall, 2 ebreak, 3 mret; mode: EX usage pattern
  task automatic run(input bit valid, input int instr, input logic [31:0] pc, input int mode);
    logic [31:0] ms, cause, tgt;
    logic [11:0] ea [3];
    logic [31:0] ed [3];
    int n, lat, idx, held, t;
    bit act, is_irq, done;
    ms = m_mstatus; act = 1'b1; is_irq = 1'b0; cause = '0; n = 0; tgt = '0;
    ea[0] = '0; ea[1] = '0; ea[2] = '0; ed[0] = '0; ed[1] = '0; ed[2] = '0;
    if (!valid)                   act = 1'b0;
    else if (instr == 3)          cause = '0;
    else if (instr == 1)          cause = 32'd11;
    else if (instr == 2)          cause = 32'd3;
    else if (ms[3] && irq_ext)    begin cause = 32'h8000_000B; is_irq = 1'b1; end
    else if (ms[3] && irq_timer)  begin cause = 32'h8000_0007; is_irq = 1'b1; end
    else                          act = 1'b0;
    if (instr == 3 && valid) begin
      n = 1; ea[0] = 12'h300;
      ed[0] = (ms & ~32'h1888) | (((ms >> 7) & 32'h1) << 3) | 32'h1880;
      tgt = m_mepc;
    end else begin
      n = 3;
      ea[0] = 12'h341; ed[0] = pc;
      ea[1] = 12'h342; ed[1] = cause;
      ea[2] = 12'h300; ed[2] = (ms & ~32'h1888) | (((ms >> 3) & 32'h1) << 7) | 32'h1800;
      tgt = m_mtvec - (m_mtvec % 4);
      if (is_irq && (m_mtvec % 4) == 1) tgt = tgt + (cause - 32'h8000_0000) * 4;
    end
    ex_mode = mode; busy_left = 0;
    tick();
    id_valid = valid; id_pc = pc;
    id_ecall = (instr == 1); id_ebreak = (instr == 2); id_mret = (instr == 3);
    samp();
    if (!act) begin
      for (int i = 0; i < 6; i++) begin
        chk("no_flush", 32'(flush), 32'd0);
        chk("no_stall", 32'(stall), 32'd0);
        tick(); samp();
      end
      clear_id();
    end else begin
      t = 0;
      while (!flush && t < 8) begin tick(); samp(); t++; end
      chk("accept_flush", 32'(flush), 32'd1);
      lat = 0; idx = 0; held = 0; done = 1'b0;
      while (!done && lat < 40) begin
        tick();
        if (lat == 0) clear_id();
        samp(); lat++;
        chk("busy_stall", 32'(stall), 32'd1);
        chk("flush_pulse", 32'(flush), 32'd0);
        if (redir) begin
          chk("redirect_pc", redir_pc, tgt);
          chk("writes_done", 32'(idx), 32'(n));
          chk("latency", 32'(lat), 32'(n + 1 + held));
          done = 1'b1;
        end else begin
          chk("we_clint", 32'(ifc.we_clint), 32'd1);
          chk("write_slot", 32'(idx < n), 32'd1);
          if (ifc.we_clint && idx < n) begin
            chk("wa_clint", 32'(ifc.wa_clint), 32'(ea[idx]));
            chk("wd_clint", ifc.wd_clint, ed[idx]);
            if (ex) held++;
            else begin
              if (ex_mode == 2 && ifc.wa_clint == 12'h341) busy_left = 3;
              idx++;
            end
          end
        end
      end
      chk("redirect_seen", 32'(done), 32'd1);
      ex_mode = 0;
      tick(); samp();
      chk("stall_release", 32'(stall), 32'd0);
    end
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_we", 32'(ifc.we_clint), 32'd0);
    chk("rst_wa", 32'(ifc.wa_clint), 32'd0);
    chk("rst_wd", ifc.wd_clint, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redir", 32'(redir), 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    m_mstatus = 32'h8; m_mtvec = 32'h200; m_mepc = '0;
    run(1'b0, 1, 32'h80, 0);            // ecall without id_valid: ignored
    run(1'b1, 1, 32'h100, 0);           // ecall -> 0x1880, redirect 0x200
    m_mepc = 32'h104;
    run(1'b1, 3, 32'h180, 0);           // mret -> 0x1888, redirect 0x104
    m_mtvec = 32'h201; irq_timer = 1'b1;
    run(1'b1, 0, 32'h300, 0);           // vectored timer -> 0x21C
    run(1'b1, 0, 32'h304, 0);           // MIE now 0: level ignored
    irq_timer = 1'b0; idle(4);
    run(1'b1, 1, 32'h400, 2);           // EX owns port 3 cycles in T_CAUSE
    m_mstatus = 32'h8;
    irq_ext = 1'b1; irq_timer = 1'b1;
    run(1'b1, 0, 32'h500, 0);           // ext wins -> 0x8000000B
    irq_ext = 1'b0;
    run(1'b1, 0, 32'h504, 0);           // timer pending, MIE 0: ignored
    run(1'b1, 3, 32'h508, 0);           // mret restores MIE
    run(1'b1, 0, 32'h50C, 0);           // pending timer traps
    irq_timer = 1'b0; idle(4);

    // reset mid-sequence
    tick(); id_valid = 1'b1; id_ecall = 1'b1; id_pc = 32'h600; samp();
    chk("mid_accept", 32'(flush), 32'd1);
    tick(); clear_id(); samp();
    chk("mid_wa_epc", 32'(ifc.wa_clint), 32'h341);
    tick(); samp();
    chk("mid_wa_cause", 32'(ifc.wa_clint), 32'h342);
    #2 rst_n = 1'b0; #1;
    pend_v = 1'b0;
    chk("mid_rst_we", 32'(ifc.we_clint), 32'd0);
    chk("mid_rst_wa", 32'(ifc.wa_clint), 32'd0);
    chk("mid_rst_wd", ifc.wd_clint, 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_flush", 32'(flush), 32'd0);
    chk("mid_rst_redir", 32'(redir), 32'd0);
    chk("mid_rst_redir_pc", redir_pc, 32'd0);
    chk("partial_mepc", m_mepc, 32'h600);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    run(1'b1, 1, 32'h700, 0);

    // randomized events
    for (int it = 0; it < 40; it++) begin
      int k;
      k = $urandom_range(0, 5);
      m_mstatus = $urandom; m_mtvec = $urandom; m_mepc = $urandom & ~32'h3;
      irq_ext   = (k == 3 || k == 5);
      irq_timer = (k == 4 || k == 5);
      run($urandom_range(0, 7) != 0, (k < 3) ? k + 1 : 0, $urandom & ~32'h3,
          $urandom_range(0, 2));
      irq_ext = 1'b0; irq_timer = 1'b0;
      idle(4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
